toggle_rr_arbiter: RTL

- Shares one W-bit bank of toggle flip-flops among N_REQ requesters.
- Each requester presents a toggle mask. A round-robin arbiter selects at most one requester per cycle and applies its mask to the bank (q <= q ^ mask).
- The block sits between multiple control agents and the shared toggle-state register and returns a one-cycle ack per serviced request.

---
 rtl/toggle_arb_pkg.sv | 25 ++
 rtl/toggle_rr_arbiter_rr_pick.sv | 17 +
 rtl/toggle_rr_arbiter.sv | 65 ++++++
 3 files changed

// File: rtl/toggle_arb_pkg.sv
// toggle_arb_pkg: shared constants and round-robin helper functions
package toggle_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_W     = 8;
    localparam int MAX_N     = 32;

    // Rotating-priority search: returns the first set bit at or after ptr,
    // wrapping modulo n. Returns ptr when nothing is eligible.
    function automatic int rr_pick(input logic [MAX_N-1:0] elig, input int ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (ptr + k) % n;
            if (elig[idx]) rr_pick = idx;
        end
    endfunction

    // One-hot encoding of an index.
    function automatic logic [MAX_N-1:0] onehot(input int idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/toggle_rr_arbiter_rr_pick.sv
// rr_pick_logic: combinational rotate-priority winner search
import toggle_arb_pkg::*;

module rr_pick_logic #(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   g,
    output logic             any
);

    assign g   = IDW'(rr_pick(MAX_N'(elig), int'(ptr), N_REQ));
    assign any = |elig;

endmodule

// File: rtl/toggle_rr_arbiter.sv
// toggle_rr_arbiter: round-robin shared toggle-bank with one-cycle acks
import toggle_arb_pkg::*;

module toggle_rr_arbiter #(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] mask,
    input  logic               hold,
    input  logic               clr,
    output logic [N_REQ-1:0]   ack,
    output logic               grant_vld,
    output logic [IDW-1:0]     grant_id,
    output logic [W-1:0]       q
);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   g;
    logic             any;
    logic [N_REQ-1:0] elig;
    logic [W-1:0]     mask_sel;

    // A requester in its ack cycle is skipped so it can drop req without a double grant.
    assign elig     = req & ~ack;
    assign mask_sel = mask[int'(g)*W +: W];

    rr_pick_logic #(.N_REQ(N_REQ)) u_pick (
        .elig (elig),
        .ptr  (ptr),
        .g    (g),
        .any  (any)
    );

    // Bank, ack, grant and pointer update: rst > clr > hold > grant > idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            ack       <= '0;
            grant_vld <= 1'b0;
            grant_id  <= '0;
            ptr       <= '0;
        end else if (clr) begin
            q         <= '0;
            ack       <= '0;
            grant_vld <= 1'b0;
        end else if (hold) begin
            ack       <= '0;
            grant_vld <= 1'b0;
        end else if (any) begin
            q         <= q ^ mask_sel;
            ack       <= N_REQ'(onehot(int'(g)));
            grant_vld <= 1'b1;
            grant_id  <= g;
            ptr       <= (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
        end else begin
            ack       <= '0;
            grant_vld <= 1'b0;
        end
    end

endmodule
